// File: rtl/vga_frame_writer_if.sv
// Command handshake between a drawing client and the VGA frame buffer write engine.
// The client drives the command fields and valid; the engine returns ready.
interface vga_frame_writer_if #(
  parameter int PIX_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [10:0]      cmd_x;
  logic [10:0]      cmd_y;
  logic [PIX_W-1:0] cmd_color;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/vga_frame_writer.sv
// Write-side engine for the VGA frame buffer: PLOT writes one pixel at y*H_RES+x,
// FILL sweeps every address 0..H_RES*V_RES-1 with one latched color.
module vga_frame_writer #(
  parameter int H_RES  = 800,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  vga_frame_writer_if.slave   cmd,
  output logic [ADDR_W-1:0]   write_address,
  output logic [PIX_W-1:0]    d,
  output logic                we,
  output logic                busy,
  output logic                err_oob
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLOT = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   addr_s;
  logic [PIX_W-1:0]    d_r;
  logic [PIX_W-1:0]    d_s;
  logic                we_r;
  logic                we_s;
  logic                busy_r;
  logic                busy_s;
  logic                err_r;
  logic                err_s;
  logic                accept_s;
  logic                in_bounds_s;
  logic [ADDR_W-1:0]   plot_addr_s;

  assign cmd.cmd_ready = (state_r == ST_IDLE) && reset_n;
  assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;
  assign in_bounds_s   = (32'(cmd.cmd_x) < 32'(H_RES)) && (32'(cmd.cmd_y) < 32'(V_RES));
  // Truncation to ADDR_W is harmless: the product is only used for in-bounds coordinates.
  assign plot_addr_s   = ADDR_W'(cmd.cmd_y) * ADDR_W'(H_RES) + ADDR_W'(cmd.cmd_x);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    d_s     = d_r;
    we_s    = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd.cmd_op) begin
            state_s = ST_FILL;
            addr_s  = '0;
            d_s     = cmd.cmd_color;
            we_s    = 1'b1;
          end else if (in_bounds_s) begin
            state_s = ST_PLOT;
            addr_s  = plot_addr_s;
            d_s     = cmd.cmd_color;
            we_s    = 1'b1;
          end else begin
            err_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PLOT: begin
        state_s = ST_IDLE;
      end
      ST_FILL: begin
        // Stop after the last address rather than wrapping back to zero.
        if (addr_r == LAST_ADDR) begin
          state_s = ST_IDLE;
        end else begin
          addr_s  = addr_r + ADDR_W'(1);
          we_s    = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      d_r     <= '0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      d_r     <= d_s;
      we_r    <= we_s;
      busy_r  <= busy_s;
      err_r   <= err_s;
    end
  end

  assign write_address = addr_r;
  assign d             = d_r;
  assign we            = we_r;
  assign busy          = busy_r;
  assign err_oob       = err_r;

endmodule
